// File: rtl/cv32e40x_mpu_arbiter_if.sv
// Bus bundle between the LSU/XIF requesters, the MPU and the data-side arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface cv32e40x_mpu_arbiter_if;
    logic [1:0]        req_valid_i;
    logic [1:0]        req_ready_o;
    logic [1:0][31:0]  req_addr_i;
    logic [1:0]        req_we_i;
    logic [1:0][3:0]   req_be_i;
    logic [1:0][31:0]  req_wdata_i;
    logic [1:0]        req_dbg_i;

    logic              mpu_trans_valid_o;
    logic              mpu_trans_ready_i;
    logic [31:0]       mpu_addr_o;
    logic              mpu_we_o;
    logic [3:0]        mpu_be_o;
    logic [31:0]       mpu_wdata_o;
    logic              mpu_dbg_o;
    logic              mpu_err_wait_o;
    logic              mpu_one_txn_pend_n_o;
    logic              mpu_err_i;

    logic              mpu_resp_valid_i;
    logic [31:0]       mpu_resp_rdata_i;
    logic [1:0]        mpu_resp_status_i;

    logic [1:0]        resp_valid_o;
    logic [31:0]       resp_rdata_o;
    logic [1:0]        resp_status_o;
    logic              xif_mpu_err_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, req_dbg_i,
        input  mpu_trans_ready_i, mpu_err_i,
        input  mpu_resp_valid_i, mpu_resp_rdata_i, mpu_resp_status_i,
        output req_ready_o,
        output mpu_trans_valid_o, mpu_addr_o, mpu_we_o, mpu_be_o, mpu_wdata_o, mpu_dbg_o,
        output mpu_err_wait_o, mpu_one_txn_pend_n_o,
        output resp_valid_o, resp_rdata_o, resp_status_o, xif_mpu_err_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, req_dbg_i,
        output mpu_trans_ready_i, mpu_err_i,
        output mpu_resp_valid_i, mpu_resp_rdata_i, mpu_resp_status_i,
        input  req_ready_o,
        input  mpu_trans_valid_o, mpu_addr_o, mpu_we_o, mpu_be_o, mpu_wdata_o, mpu_dbg_o,
        input  mpu_err_wait_o, mpu_one_txn_pend_n_o,
        input  resp_valid_o, resp_rdata_o, resp_status_o, xif_mpu_err_o
    );
endinterface

// File: rtl/cv32e40x_mpu_arbiter.sv
// Round-robin arbiter sharing the data-side MPU port between LSU (0) and XIF (1),
// with OBI grant locking, outstanding-transaction counting and in-order response routing.
module cv32e40x_mpu_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cv32e40x_mpu_arbiter_if.slave     bus
);

    logic [2:0]  r_cnt;
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [3:0]  r_fifo;
    logic        r_last;
    logic        r_lock;
    logic        r_lock_id;
    logic        r_xif_err;

    logic        w_full;
    logic        w_gnt_vld;
    logic        w_gnt_id;
    logic        w_trans_valid;
    logic        w_hs;
    logic        w_xif_err_hs;
    logic        w_push;
    logic        w_pop;
    logic        w_head;
    logic [2:0]  w_cnt_n;
    logic [1:0]  w_req_ready;
    logic [1:0]  w_resp_valid;
    logic [1:0]  w_wptr_n;
    logic [1:0]  w_rptr_n;

    assign w_full = (r_cnt == 3'(DEPTH));

    // A locked grant holds the unaccepted request; otherwise ties go to the requester not served last.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (!w_full) begin
            if (r_lock) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = r_lock_id;
            end else begin
                case (bus.req_valid_i)
                    2'b01:   begin w_gnt_vld = 1'b1; w_gnt_id = 1'b0;    end
                    2'b10:   begin w_gnt_vld = 1'b1; w_gnt_id = 1'b1;    end
                    2'b11:   begin w_gnt_vld = 1'b1; w_gnt_id = !r_last; end
                    default: begin w_gnt_vld = 1'b0; w_gnt_id = 1'b0;    end
                endcase
            end
        end
    end

    assign w_trans_valid = w_gnt_vld && bus.req_valid_i[w_gnt_id];
    assign w_hs          = w_trans_valid && bus.mpu_trans_ready_i;
    assign w_xif_err_hs  = w_hs && w_gnt_id && bus.mpu_err_i;
    assign w_push        = w_hs && !w_xif_err_hs;
    assign w_pop         = bus.mpu_resp_valid_i && (r_cnt != 3'd0);
    assign w_head        = r_fifo[r_rptr];
    assign w_wptr_n      = (r_wptr == 2'(DEPTH - 1)) ? 2'd0 : r_wptr + 2'd1;
    assign w_rptr_n      = (r_rptr == 2'(DEPTH - 1)) ? 2'd0 : r_rptr + 2'd1;

    always_comb begin
        w_cnt_n      = r_cnt;
        w_req_ready  = 2'b00;
        w_resp_valid = 2'b00;
        if (w_push && !w_pop) begin
            w_cnt_n = r_cnt + 3'd1;
        end else if (w_pop && !w_push) begin
            w_cnt_n = r_cnt - 3'd1;
        end
        if (w_trans_valid) begin
            w_req_ready[w_gnt_id] = bus.mpu_trans_ready_i;
        end
        if (w_pop) begin
            w_resp_valid[w_head] = 1'b1;
        end
    end

    assign bus.mpu_trans_valid_o    = w_trans_valid;
    assign bus.mpu_addr_o           = w_trans_valid ? bus.req_addr_i[w_gnt_id]  : 32'd0;
    assign bus.mpu_we_o             = w_trans_valid ? bus.req_we_i[w_gnt_id]    : 1'b0;
    assign bus.mpu_be_o             = w_trans_valid ? bus.req_be_i[w_gnt_id]    : 4'd0;
    assign bus.mpu_wdata_o          = w_trans_valid ? bus.req_wdata_i[w_gnt_id] : 32'd0;
    assign bus.mpu_dbg_o            = w_trans_valid ? bus.req_dbg_i[w_gnt_id]   : 1'b0;
    // LSU errors come back as an MPU response; XIF errors are flagged at accept time.
    assign bus.mpu_err_wait_o       = w_trans_valid && !w_gnt_id;
    assign bus.mpu_one_txn_pend_n_o = (w_cnt_n == 3'd1);
    assign bus.req_ready_o          = w_req_ready;
    assign bus.resp_valid_o         = w_resp_valid;
    assign bus.resp_rdata_o         = bus.mpu_resp_valid_i ? bus.mpu_resp_rdata_i  : 32'd0;
    assign bus.resp_status_o        = bus.mpu_resp_valid_i ? bus.mpu_resp_status_i : 2'd0;
    assign bus.xif_mpu_err_o        = r_xif_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 3'd0;
            r_wptr    <= 2'd0;
            r_rptr    <= 2'd0;
            r_fifo    <= 4'd0;
            r_last    <= 1'b1;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_xif_err <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_n;
            r_xif_err <= w_xif_err_hs;
            r_lock    <= w_trans_valid && !bus.mpu_trans_ready_i;
            if (w_trans_valid && !bus.mpu_trans_ready_i) begin
                r_lock_id <= w_gnt_id;
            end
            if (w_hs) begin
                r_last <= w_gnt_id;
            end
            if (w_push) begin
                r_fifo[r_wptr] <= w_gnt_id;
                r_wptr         <= w_wptr_n;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_n;
            end
        end
    end

    logic [2:0] w_occ;
    assign w_occ = (r_wptr >= r_rptr) ? 3'(r_wptr - r_rptr) : 3'(r_wptr) + 3'(DEPTH) - 3'(r_rptr);

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= 3'(DEPTH));
    a_occ_match: assert property (@(posedge clk) disable iff (!rst_n)
        w_occ == (w_full ? 3'd0 : r_cnt));
    a_no_empty_resp: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mpu_resp_valid_i |-> (r_cnt != 3'd0));
    a_lock_stable: assert property (@(posedge clk) disable iff (!rst_n)
        r_lock |-> ($stable(bus.mpu_addr_o) && $stable(bus.mpu_we_o) && $stable(bus.mpu_be_o)
                    && $stable(bus.mpu_wdata_o) && $stable(bus.mpu_dbg_o)));

endmodule
